// File: rtl/fifo_pkg.sv
// Shared definitions for the stream FIFO.
//   fifo_state_t : occupancy state (empty / partial / full)
//   ptr_w()      : pointer width for a given depth, at least 1 bit
package fifo_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } fifo_state_t;

   function automatic int ptr_w(input int depth);
      int lg;
      lg = $clog2(depth);
      if (lg < 1) begin
         return 1;
      end else begin
         return lg;
      end
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the stream FIFO: one synchronous write port and one
// asynchronous read port. The contents are never reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int w     = 8,
   parameter int depth = 4
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ptr_w(depth)-1:0]   waddr,
   input  logic [w-1:0]              wdata,
   input  logic [ptr_w(depth)-1:0]   raddr,
   output logic [w-1:0]              rdata
);

   logic [w-1:0] mem_r [0:depth-1];

   // Write port: capture wdata on a qualified clock edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read port: head entry is visible without waiting for a clock.
   always_comb begin
      rdata = mem_r[raddr];
   end

endmodule

// File: rtl/fifo_stream_buffer.sv
// Valid/ready stream FIFO with first-word-fall-through output, occupancy
// count and synchronous flush. Depth need not be a power of two.
// Optional feature: define FIFO_WATERMARK_EN to add almost_full and
// almost_empty outputs (registered, derived from the next-cycle count).
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   flush    : synchronous clear, active high
//   valid_wr : producer offers in
//   ready_wr : buffer can accept a word
//   in       : write data
//   valid_rd : o holds a valid head word
//   ready_rd : consumer takes o
//   o        : head-of-queue data, zero while valid_rd is low
//   count    : current occupancy
//   almost_full / almost_empty : watermark flags (FIFO_WATERMARK_EN only)
module fifo_stream_buffer
   import fifo_pkg::*;
#(
   parameter int w      = 8,
   parameter int depth  = 4,
   parameter int af_lvl = depth - 1,
   parameter int ae_lvl = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         valid_wr,
   output logic                         ready_wr,
   input  logic [w-1:0]                 in,
   output logic                         valid_rd,
   input  logic                         ready_rd,
   output logic [w-1:0]                 o,
   output logic [$clog2(depth+1)-1:0]   count
`ifdef FIFO_WATERMARK_EN
   ,
   output logic                         almost_full,
   output logic                         almost_empty
`endif
);

   localparam int PW = ptr_w(depth);
   localparam int CW = $clog2(depth + 1);

   fifo_state_t     state_r;
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_nxt_s;
   logic            wr_en_s;
   logic            rd_en_s;
   logic [w-1:0]    rdata_s;

   // Handshake decode straight from the registered state, so no
   // combinational path exists from ready_rd or valid_wr to the flags.
   always_comb begin
      valid_rd = (state_r != ST_EMPTY);
      ready_wr = (state_r != ST_FULL);
   end

   // Accepted transfers; a flush cycle discards both sides.
   always_comb begin
      wr_en_s = valid_wr & ready_wr & ~flush;
      rd_en_s = valid_rd & ready_rd & ~flush;
   end

   // Next occupancy: simultaneous read and write cancel out.
   always_comb begin
      count_nxt_s = count_r;
      if (flush) begin
         count_nxt_s = {CW{1'b0}};
      end else if (wr_en_s && !rd_en_s) begin
         count_nxt_s = count_r + CW'(1);
      end else if (rd_en_s && !wr_en_s) begin
         count_nxt_s = count_r - CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Pointers and count; wrap uses an explicit compare so non-power-of-two
   // depths work.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         count_r <= count_nxt_s;
         if (wr_en_s) begin
            wr_ptr_r <= (wr_ptr_r == PW'(depth - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= (rd_ptr_r == PW'(depth - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
         end
      end
   end

   // Occupancy state machine.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_EMPTY;
      end else if (flush) begin
         state_r <= ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (wr_en_s) begin
                  state_r <= ST_PARTIAL;
               end else begin
                  state_r <= ST_EMPTY;
               end
            end
            ST_PARTIAL: begin
               if (wr_en_s && !rd_en_s && (count_r == CW'(depth - 1))) begin
                  state_r <= ST_FULL;
               end else if (rd_en_s && !wr_en_s && (count_r == CW'(1))) begin
                  state_r <= ST_EMPTY;
               end else begin
                  state_r <= ST_PARTIAL;
               end
            end
            ST_FULL: begin
               if (rd_en_s) begin
                  state_r <= ST_PARTIAL;
               end else begin
                  state_r <= ST_FULL;
               end
            end
            default: begin
               state_r <= ST_EMPTY;
            end
         endcase
      end
   end

   fifo_mem #(
      .w     (w),
      .depth (depth)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en_s),
      .waddr (wr_ptr_r),
      .wdata (in),
      .raddr (rd_ptr_r),
      .rdata (rdata_s)
   );

   // Output data is zeroed while there is no valid head word.
   always_comb begin
      if (valid_rd) begin
         o = rdata_s;
      end else begin
         o = {w{1'b0}};
      end
   end

   always_comb begin
      count = count_r;
   end

`ifdef FIFO_WATERMARK_EN
   logic almost_full_r;
   logic almost_empty_r;

   // Watermarks track the count that will be present after this edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
      end else if (flush) begin
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
      end else begin
         almost_full_r  <= (count_nxt_s >= CW'(af_lvl));
         almost_empty_r <= (count_nxt_s <= CW'(ae_lvl));
      end
   end

   always_comb begin
      almost_full  = almost_full_r;
      almost_empty = almost_empty_r;
   end
`endif

endmodule

// File: tb/tb_fifo_stream_buffer.sv
module tb_fifo_stream_buffer;

   logic       clk;
   logic       rst;

   // depth-4 instance
   logic       flush4, vw4, rr4, rw4, vr4;
   logic [7:0] din4, o4;
   logic [2:0] count4;
`ifdef FIFO_WATERMARK_EN
   logic       af4, ae4;
   logic       af3, ae3;
`endif

   // depth-3 instance
   logic       flush3, vw3, rr3, rw3, vr3;
   logic [7:0] din3, o3;
   logic [1:0] count3;

   int n_cmp;
   int n_fail;

   logic [7:0] q4[$];
   logic [7:0] q3[$];

   fifo_stream_buffer #(.w(8), .depth(4), .af_lvl(3), .ae_lvl(1)) u_dut4 (
      .clk(clk), .rst(rst), .flush(flush4),
      .valid_wr(vw4), .ready_wr(rw4), .in(din4),
      .valid_rd(vr4), .ready_rd(rr4), .o(o4), .count(count4)
`ifdef FIFO_WATERMARK_EN
      , .almost_full(af4), .almost_empty(ae4)
`endif
   );

   fifo_stream_buffer #(.w(8), .depth(3)) u_dut3 (
      .clk(clk), .rst(rst), .flush(flush3),
      .valid_wr(vw3), .ready_wr(rw3), .in(din3),
      .valid_rd(vr3), .ready_rd(rr3), .o(o3), .count(count3)
`ifdef FIFO_WATERMARK_EN
      , .almost_full(af3), .almost_empty(ae3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle on the selected instance: drive, sample at negedge,
   // report which transfers the handshake accepted, then step past the edge.
   task automatic cyc(input bit d3, input logic vw, input logic [7:0] din,
                      input logic rr, input logic fl,
                      output bit wa, output bit ra, output logic [7:0] dout);
      if (d3) begin
         vw3 = vw; din3 = din; rr3 = rr; flush3 = fl;
         vw4 = 1'b0; rr4 = 1'b0; flush4 = 1'b0;
      end else begin
         vw4 = vw; din4 = din; rr4 = rr; flush4 = fl;
         vw3 = 1'b0; rr3 = 1'b0; flush3 = 1'b0;
      end
      @(negedge clk);
      if (d3) begin
         wa = vw & rw3; ra = rr & vr3; dout = o3;
      end else begin
         wa = vw & rw4; ra = rr & vr4; dout = o4;
      end
      @(posedge clk);
      #1;
      vw4 = 1'b0; rr4 = 1'b0; flush4 = 1'b0;
      vw3 = 1'b0; rr3 = 1'b0; flush3 = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (count4 !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count4); end
      n_cmp++; if (vr4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_rd got %b want 0", vr4); end
      n_cmp++; if (rw4 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_wr got %b want 1", rw4); end
      n_cmp++; if (o4 !== 8'h00) begin n_fail++; $display("FAIL reset_o got %h want 00", o4); end
`ifdef FIFO_WATERMARK_EN
      n_cmp++; if (af4 !== 1'b0 || ae4 !== 1'b1) begin n_fail++; $display("FAIL reset_wm got af=%b ae=%b want 0/1", af4, ae4); end
`endif
   endtask

   task automatic test_fill();
      bit wa, ra;
      logic [7:0] d;
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, vals[i], 1'b0, 1'b0, wa, ra, d);
         n_cmp++; if (wa !== 1'b1) begin n_fail++; $display("FAIL fill_accept[%0d] got %b want 1", i, wa); end
         if (wa) q4.push_back(vals[i]);
         n_cmp++; if (count4 !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count4, i + 1); end
`ifdef FIFO_WATERMARK_EN
         n_cmp++; if (af4 !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, af4, (i + 1 >= 3)); end
         n_cmp++; if (ae4 !== (i + 1 <= 1)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b want %b", i, ae4, (i + 1 <= 1)); end
`endif
      end
      n_cmp++; if (rw4 !== 1'b0) begin n_fail++; $display("FAIL full_ready_wr got %b want 0", rw4); end
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, wa, ra, d);
         n_cmp++; if (wa !== 1'b0 || count4 !== 3'd4) begin n_fail++; $display("FAIL full_holdoff got wa=%b count=%0d want 0/4", wa, count4); end
      end
   endtask

   task automatic test_fwft();
      bit wa, ra;
      logic [7:0] d, e;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, wa, ra, d);
         n_cmp++;
         if (!ra || q4.size() == 0) begin
            n_fail++; $display("FAIL fwft_read[%0d] got ra=%b qsize=%0d want read", i, ra, q4.size());
         end else begin
            e = q4.pop_front();
            if (d !== e) begin n_fail++; $display("FAIL fwft_data[%0d] got %h want %h", i, d, e); end
         end
      end
      n_cmp++; if (vr4 !== 1'b0 || count4 !== 3'd0 || o4 !== 8'h00) begin
         n_fail++; $display("FAIL fwft_drained got vr=%b count=%0d o=%h want 0/0/00", vr4, count4, o4);
      end
   endtask

   task automatic test_back_to_back();
      bit wa, ra;
      logic [7:0] d, e;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, wa, ra, d);
         if (wa) q4.push_back(8'hA0 + 8'(i));
      end
      for (int i = 2; i < 12; i++) begin
         cyc(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0, wa, ra, d);
         n_cmp++; if (!(wa && ra)) begin n_fail++; $display("FAIL b2b_both[%0d] got wa=%b ra=%b want 1/1", i, wa, ra); end
         if (wa) q4.push_back(8'hA0 + 8'(i));
         if (ra && q4.size() != 0) begin
            e = q4.pop_front();
            n_cmp++; if (d !== e) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, d, e); end
         end
         n_cmp++; if (count4 !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want 2", i, count4); end
      end
      // top up to full, then offer both at once
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, wa, ra, d);
         if (wa) q4.push_back(8'hC0 + 8'(i));
      end
      n_cmp++; if (count4 !== 3'd4) begin n_fail++; $display("FAIL full_topup got %0d want 4", count4); end
      cyc(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, wa, ra, d);
      n_cmp++; if (wa !== 1'b0 || ra !== 1'b1) begin n_fail++; $display("FAIL full_both got wa=%b ra=%b want 0/1", wa, ra); end
      if (wa) q4.push_back(8'hEE);
      if (ra && q4.size() != 0) begin
         e = q4.pop_front();
         n_cmp++; if (d !== e) begin n_fail++; $display("FAIL full_both_data got %h want %h", d, e); end
      end
      n_cmp++; if (count4 !== 3'd3) begin n_fail++; $display("FAIL full_both_count got %0d want 3", count4); end
      while (q4.size() != 0) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, wa, ra, d);
         e = q4.pop_front();
         n_cmp++; if (!ra || d !== e) begin n_fail++; $display("FAIL drain_data got ra=%b d=%h want 1/%h", ra, d, e); end
      end
   endtask

   task automatic test_reset_mid();
      bit wa, ra;
      logic [7:0] d;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, wa, ra, d);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (count4 !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", count4); end
      n_cmp++; if (vr4 !== 1'b0 || rw4 !== 1'b1 || o4 !== 8'h00) begin
         n_fail++; $display("FAIL midrst_flags got vr=%b rw=%b o=%h want 0/1/00", vr4, rw4, o4);
      end
      rst = 1'b1;
      q4.delete();
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, wa, ra, d);
      n_cmp++; if (ra !== 1'b0) begin n_fail++; $display("FAIL midrst_stale got ra=%b d=%h want no read", ra, d); end
      cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, wa, ra, d);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, wa, ra, d);
      n_cmp++; if (ra !== 1'b1 || d !== 8'h77) begin n_fail++; $display("FAIL midrst_next got ra=%b d=%h want 1/77", ra, d); end
   endtask

   task automatic test_flush();
      bit wa, ra;
      logic [7:0] d;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, wa, ra, d);
      end
      n_cmp++; if (count4 !== 3'd3) begin n_fail++; $display("FAIL preflush_count got %0d want 3", count4); end
      cyc(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, wa, ra, d);
      n_cmp++; if (count4 !== 3'd0 || vr4 !== 1'b0) begin n_fail++; $display("FAIL flush_state got count=%0d vr=%b want 0/0", count4, vr4); end
`ifdef FIFO_WATERMARK_EN
      n_cmp++; if (af4 !== 1'b0 || ae4 !== 1'b1) begin n_fail++; $display("FAIL flush_wm got af=%b ae=%b want 0/1", af4, ae4); end
`endif
      cyc(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, wa, ra, d);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, wa, ra, d);
      n_cmp++; if (ra !== 1'b1 || d !== 8'h5A) begin n_fail++; $display("FAIL postflush_data got ra=%b d=%h want 1/5a", ra, d); end
      n_cmp++; if (count4 !== 3'd0) begin n_fail++; $display("FAIL postflush_count got %0d want 0", count4); end
   endtask

   task automatic test_wrap();
      bit wa, ra;
      logic [7:0] d, e;
      int sent, recv, cycles;
      sent = 0; recv = 0; cycles = 0;
      while (recv < 20 && cycles < 400) begin
         cyc(1'b1, (sent < 20), 8'(sent), 1'($urandom_range(0, 1)), 1'b0, wa, ra, d);
         cycles++;
         if (wa) begin q3.push_back(8'(sent)); sent++; end
         if (ra) begin
            n_cmp++;
            if (q3.size() == 0) begin
               n_fail++; $display("FAIL wrap_unexpected got %h want no read", d);
            end else begin
               e = q3.pop_front();
               if (d !== e) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", recv, d, e); end
            end
            recv++;
         end
         n_cmp++; if (count3 > 2'd3 || count3 !== 2'(q3.size())) begin
            n_fail++; $display("FAIL wrap_count got %0d want %0d", count3, q3.size());
         end
      end
      n_cmp++; if (recv != 20) begin n_fail++; $display("FAIL wrap_budget got %0d words want 20", recv); end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b0;
      flush4 = 1'b0; vw4 = 1'b0; rr4 = 1'b0; din4 = 8'h00;
      flush3 = 1'b0; vw3 = 1'b0; rr3 = 1'b0; din3 = 8'h00;
      #12;
      test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      test_fill();
      test_fwft();
      test_back_to_back();
      test_reset_mid();
      test_flush();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
